// File: rtl/instr_delay_ctrl_pkg.sv
// Shared constants and width helpers for the instruction delay controller
// and the instruction buffer attached to it.
package instr_delay_ctrl_pkg;

    localparam int unsigned DEFAULT_INSTR_WORD_SIZE = 32'd32;
    localparam int unsigned DEFAULT_BS              = 32'd16;

    // Width of a slot address into a buffer of 'depth' slots (at least one bit)
    function automatic int unsigned index_width(input int unsigned depth);
        if (depth > 32'd1) begin
            return $clog2(depth);
        end else begin
            return 32'd1;
        end
    endfunction

    // Width needed to count 0..depth valid entries
    function automatic int unsigned flight_width(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

endpackage

// File: rtl/instr_delay_ctrl_if.sv
// Bundle of the instruction stream, the buffer bus and the delayed output.
// slave  : the delay controller's view.
// master : the surrounding environment (producer, buffer and consumer).
interface instr_delay_ctrl_if
    import instr_delay_ctrl_pkg::*;
#(
    parameter int unsigned Instr_word_size = DEFAULT_INSTR_WORD_SIZE,
    parameter int unsigned bs              = DEFAULT_BS
);

    logic                             in_valid;
    logic [Instr_word_size-1:0]       in_instr;
    logic                             flush;
    logic                             buf_rst;
    logic [index_width(bs)-1:0]       buffer_index;
    logic [Instr_word_size-1:0]       buf_instr;
    logic [Instr_word_size-1:0]       buf_instr_out;
    logic                             out_valid;
    logic [Instr_word_size-1:0]       out_instr;
    logic [flight_width(bs)-1:0]      in_flight;

    modport slave (
        input  in_valid,
        input  in_instr,
        input  flush,
        input  buf_instr_out,
        output buf_rst,
        output buffer_index,
        output buf_instr,
        output out_valid,
        output out_instr,
        output in_flight
    );

    modport master (
        output in_valid,
        output in_instr,
        output flush,
        output buf_instr_out,
        input  buf_rst,
        input  buffer_index,
        input  buf_instr,
        input  out_valid,
        input  out_instr,
        input  in_flight
    );

endinterface

// File: rtl/instr_delay_ring.sv
// Valid-bit ring that shadows the instruction buffer slot by slot, plus a
// running count of valid slots. The bit read at the current slot becomes the
// registered output-valid flag; the new input-valid bit replaces it.
module instr_delay_ring
    import instr_delay_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_BS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [index_width(DEPTH)-1:0]      idx,
    input  logic                               set_bit,
    input  logic                               flush,
    output logic                               out_bit,
    output logic [flight_width(DEPTH)-1:0]     count
);

    localparam int unsigned  FW        = flight_width(DEPTH);
    localparam logic [FW-1:0] CNT_FULL = FW'(DEPTH);
    localparam logic [FW-1:0] CNT_ONE  = FW'(32'd1);
    localparam logic [FW-1:0] CNT_ZERO = FW'(32'd0);

    logic [DEPTH-1:0] ring_r;
    logic             out_bit_r;
    logic [FW-1:0]    count_r;
    logic             slot_bit_s;
    logic [FW-1:0]    count_nxt_s;

    // Next occupancy: +1 for an entering entry, -1 for a leaving one, clamped to 0..DEPTH
    always_comb begin
        slot_bit_s  = ring_r[idx];
        count_nxt_s = count_r;
        if (set_bit && !slot_bit_s) begin
            if (count_r != CNT_FULL) begin
                count_nxt_s = count_r + CNT_ONE;
            end else begin
                count_nxt_s = count_r;
            end
        end else if (!set_bit && slot_bit_s) begin
            if (count_r != CNT_ZERO) begin
                count_nxt_s = count_r - CNT_ONE;
            end else begin
                count_nxt_s = count_r;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Ring, output-valid flag and occupancy; flush wipes everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ring_r    <= {DEPTH{1'b0}};
            out_bit_r <= 1'b0;
            count_r   <= CNT_ZERO;
        end else if (flush) begin
            ring_r    <= {DEPTH{1'b0}};
            out_bit_r <= 1'b0;
            count_r   <= CNT_ZERO;
        end else begin
            ring_r[idx] <= set_bit;
            out_bit_r   <= slot_bit_s;
            count_r     <= count_nxt_s;
        end
    end

    assign out_bit = out_bit_r;
    assign count   = count_r;

endmodule

// File: rtl/instr_delay_ctrl.sv
// Fixed-latency instruction delay line. An external bs-slot buffer is
// written and read at the same slot every cycle, so an instruction written
// now reappears on the buffer's registered read port exactly bs edges later.
// This block steps the slot pointer, gates write data, and tracks which
// slots hold real instructions so that bubbles and flushed entries never
// surface as valid output.
module instr_delay_ctrl
    import instr_delay_ctrl_pkg::*;
#(
    parameter int unsigned Instr_word_size = DEFAULT_INSTR_WORD_SIZE,
    parameter int unsigned bs              = DEFAULT_BS
) (
    input  logic               clk,
    input  logic               rst,
    instr_delay_ctrl_if.slave  bus
);

    localparam int unsigned   IW       = index_width(bs);
    localparam int unsigned   FW       = flight_width(bs);
    localparam logic [IW-1:0] IDX_LAST = IW'(bs - 32'd1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(32'd0);

    logic [IW-1:0]              idx_r;
    logic                       accept_s;
    logic                       out_valid_s;
    logic [FW-1:0]              in_flight_s;
    logic [Instr_word_size-1:0] buf_instr_s;
    logic [Instr_word_size-1:0] out_instr_s;

    // Slot pointer: advances every edge with no stall, wrapping at bs-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r <= IDX_ZERO;
        end else if (idx_r == IDX_LAST) begin
            idx_r <= IDX_ZERO;
        end else begin
            idx_r <= idx_r + IDX_ONE;
        end
    end

    // Write data: a flushed or absent instruction is stored as zeros
    always_comb begin
        accept_s = bus.in_valid & ~bus.flush;
        if (accept_s) begin
            buf_instr_s = bus.in_instr;
        end else begin
            buf_instr_s = {Instr_word_size{1'b0}};
        end
    end

    // Output data: only expose buffer read data behind a valid flag
    always_comb begin
        if (out_valid_s) begin
            out_instr_s = bus.buf_instr_out;
        end else begin
            out_instr_s = {Instr_word_size{1'b0}};
        end
    end

    instr_delay_ring #(
        .DEPTH (bs)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .idx     (idx_r),
        .set_bit (accept_s),
        .flush   (bus.flush),
        .out_bit (out_valid_s),
        .count   (in_flight_s)
    );

    // The buffer shares this block's reset, but active-high and asynchronous
    assign bus.buf_rst      = ~rst;
    assign bus.buffer_index = idx_r;
    assign bus.buf_instr    = buf_instr_s;
    assign bus.out_valid    = out_valid_s;
    assign bus.out_instr    = out_instr_s;
    assign bus.in_flight    = in_flight_s;

endmodule

// File: tb/tb_instr_delay_ctrl.sv
// Directed bench for instr_delay_ctrl: a 16-deep and a 5-deep instance,
// each wired to a behavioural slot buffer.
module tb_instr_delay_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   expf;

    instr_delay_ctrl_if #(.Instr_word_size(32), .bs(16)) b16 ();
    instr_delay_ctrl_if #(.Instr_word_size(32), .bs(5))  b5 ();

    instr_delay_ctrl #(.Instr_word_size(32), .bs(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16.slave)
    );

    instr_delay_ctrl #(.Instr_word_size(32), .bs(5)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (b5.slave)
    );

    always #5 clk = ~clk;

    // Behavioural buffers: write new data, register old slot contents
    logic [31:0] mem16 [16];
    logic [31:0] rd16;
    logic [31:0] mem5 [5];
    logic [31:0] rd5;

    always @(posedge clk or posedge b16.buf_rst) begin
        if (b16.buf_rst) begin
            rd16 <= 32'd0;
        end else begin
            rd16 <= mem16[b16.buffer_index];
            mem16[b16.buffer_index] <= b16.buf_instr;
        end
    end

    always @(posedge clk or posedge b5.buf_rst) begin
        if (b5.buf_rst) begin
            rd5 <= 32'd0;
        end else begin
            rd5 <= mem5[b5.buffer_index];
            mem5[b5.buffer_index] <= b5.buf_instr;
        end
    end

    assign b16.buf_instr_out = rd16;
    assign b5.buf_instr_out  = rd5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        b16.in_valid = 1'b0; b16.in_instr = 32'd0; b16.flush = 1'b0;
        b5.in_valid  = 1'b0; b5.in_instr  = 32'd0; b5.flush  = 1'b0;

        // Reset state, before any clock edge
        #1;
        check("rst_index",     32'(b16.buffer_index), 32'd0);
        check("rst_out_valid", 32'(b16.out_valid),    32'd0);
        check("rst_out_instr", b16.out_instr,         32'd0);
        check("rst_in_flight", 32'(b16.in_flight),    32'd0);
        check("rst_buf_rst",   32'(b16.buf_rst),      32'd1);
        #11;
        rst = 1'b1;
        cyc = 0;
        step();
        check("idx_after_first_edge", 32'(b16.buffer_index), 32'd1);
        check("buf_rst_released",     32'(b16.buf_rst),      32'd0);

        // Single instruction, latency 16, one-cycle output
        b16.in_valid = 1'b1; b16.in_instr = 32'hDEAD0001;
        #1;
        check("t1_buf_instr_pass", b16.buf_instr, 32'hDEAD0001);
        step();
        b16.in_valid = 1'b0; b16.in_instr = 32'd0;
        #1;
        check("t1_buf_instr_idle", b16.buf_instr, 32'd0);
        check("t1_in_flight",      32'(b16.in_flight), 32'd1);
        for (int i = 1; i <= 15; i++) begin
            step();
            check($sformatf("t1_early_valid_%0d", i), 32'(b16.out_valid), 32'd0);
        end
        step();
        check("t1_out_valid",  32'(b16.out_valid), 32'd1);
        check("t1_out_instr",  b16.out_instr,      32'hDEAD0001);
        check("t1_in_flight0", 32'(b16.in_flight), 32'd0);
        step();
        check("t1_valid_drop", 32'(b16.out_valid), 32'd0);
        check("t1_instr_drop", b16.out_instr,      32'd0);

        // 40 back-to-back instructions 1..40
        for (int s = 1; s <= 57; s++) begin
            if (s <= 40) begin
                b16.in_valid = 1'b1; b16.in_instr = 32'(s);
            end else begin
                b16.in_valid = 1'b0; b16.in_instr = 32'd0;
            end
            step();
            if (s <= 40) expf = (s < 16) ? s : 16;
            else         expf = (56 - s > 0) ? 56 - s : 0;
            check($sformatf("t2_idx_%0d", s),   32'(b16.buffer_index), 32'(cyc % 16));
            check($sformatf("t2_fl_%0d", s),    32'(b16.in_flight),    32'(expf));
            if (s > 16 && s <= 56) begin
                check($sformatf("t2_valid_%0d", s), 32'(b16.out_valid), 32'd1);
                check($sformatf("t2_instr_%0d", s), b16.out_instr,      32'(s - 16));
            end else begin
                check($sformatf("t2_valid_%0d", s), 32'(b16.out_valid), 32'd0);
                check($sformatf("t2_instr_%0d", s), b16.out_instr,      32'd0);
            end
        end

        // Five instructions, flush on the third edge after the stream
        for (int s = 1; s <= 5; s++) begin
            b16.in_valid = 1'b1; b16.in_instr = 32'h3000_0000 + 32'(s);
            step();
            check($sformatf("t3_fl_%0d", s), 32'(b16.in_flight), 32'(s));
        end
        b16.in_valid = 1'b0; b16.in_instr = 32'd0;
        step();
        step();
        check("t3_fl_before_flush", 32'(b16.in_flight), 32'd5);
        b16.flush = 1'b1;
        step();
        b16.flush = 1'b0;
        check("t3_fl_after_flush",  32'(b16.in_flight), 32'd0);
        check("t3_valid_at_flush",  32'(b16.out_valid), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("t3_valid_%0d", i), 32'(b16.out_valid), 32'd0);
        end
        check("t3_fl_end", 32'(b16.in_flight), 32'd0);

        // Flush and in_valid together: input is discarded
        b16.in_valid = 1'b1; b16.in_instr = 32'h0000_00AA; b16.flush = 1'b1;
        #1;
        check("t4_buf_instr_gated", b16.buf_instr, 32'd0);
        step();
        b16.in_valid = 1'b0; b16.in_instr = 32'd0; b16.flush = 1'b0;
        check("t4_fl", 32'(b16.in_flight), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            step();
            check($sformatf("t4_valid_%0d", i), 32'(b16.out_valid), 32'd0);
            check($sformatf("t4_instr_%0d", i), b16.out_instr,      32'd0);
        end

        // Eight in flight, then an asynchronous reset pulse between edges
        for (int s = 1; s <= 8; s++) begin
            b16.in_valid = 1'b1; b16.in_instr = 32'h5000_0000 + 32'(s);
            step();
        end
        b16.in_valid = 1'b0; b16.in_instr = 32'd0;
        check("t5_fl_before_rst", 32'(b16.in_flight), 32'd8);
        #2;
        rst = 1'b0;
        #1;
        check("t5_idx",       32'(b16.buffer_index), 32'd0);
        check("t5_out_valid", 32'(b16.out_valid),    32'd0);
        check("t5_out_instr", b16.out_instr,         32'd0);
        check("t5_in_flight", 32'(b16.in_flight),    32'd0);
        check("t5_buf_rst",   32'(b16.buf_rst),      32'd1);
        check("t5_idx5",      32'(b5.buffer_index),  32'd0);
        rst = 1'b1;
        cyc = 0;

        // Depth-5 instance: index wrap 0..4,0 and 5-edge latency
        b5.in_valid = 1'b1; b5.in_instr = 32'hCAFE0005;
        for (int s = 1; s <= 20; s++) begin
            step();
            if (s == 1) begin
                b5.in_valid = 1'b0; b5.in_instr = 32'd0;
            end
            check($sformatf("t5_valid16_%0d", s), 32'(b16.out_valid),    32'd0);
            check($sformatf("t5_idx16_%0d", s),   32'(b16.buffer_index), 32'(s % 16));
            check($sformatf("t6_idx5_%0d", s),    32'(b5.buffer_index),  32'(s % 5));
            if (s == 6) begin
                check("t6_valid5", 32'(b5.out_valid), 32'd1);
                check("t6_instr5", b5.out_instr,      32'hCAFE0005);
            end else begin
                check($sformatf("t6_valid5_%0d", s), 32'(b5.out_valid), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
